// File: rtl/lcd_msg_arbiter.sv
// Round-robin arbiter sharing one LCD driver between four message sources.
// The winner's message select is latched and held until write plus dwell completes.
module lcd_msg_arbiter #(
  parameter int unsigned NUM_REQ      = 4,
  parameter int unsigned MSG_W        = 4,
  parameter int unsigned DWELL_CYCLES = 50000000,
  parameter int unsigned DW_W         = 26
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NUM_REQ-1:0]       req,
  input  logic [NUM_REQ*MSG_W-1:0] msg_in,
  input  logic                     lcd_busy,
  output logic [MSG_W-1:0]         lcd_char_sel,
  output logic                     lcd_load,
  output logic [NUM_REQ-1:0]       grant,
  output logic [NUM_REQ-1:0]       ack,
  output logic                     busy
);

  localparam int unsigned PtrW = 2;
  localparam logic [DW_W-1:0] DwellLoad = DW_W'(DWELL_CYCLES - 1);

  typedef enum logic [1:0] {
    StIdle,
    StLoad,
    StWaitLcd,
    StDwell
  } state_e;

  state_e             state_q, state_d;
  logic [PtrW-1:0]    owner_q, owner_d;
  logic [PtrW-1:0]    rr_ptr_q, rr_ptr_d;
  logic [DW_W-1:0]    dwell_q, dwell_d;
  logic [MSG_W-1:0]   sel_q, sel_d;
  logic               load_q, load_d;
  logic [NUM_REQ-1:0] grant_q, grant_d;
  logic [NUM_REQ-1:0] ack_q, ack_d;
  logic               busy_q, busy_d;

  logic               win_found;
  logic [PtrW-1:0]    win_idx;
  logic [PtrW-1:0]    cand;
  logic [MSG_W-1:0]   win_msg;

  // Scan from rr_ptr upward (mod 4); first set request wins.
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    cand      = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      cand = rr_ptr_q + PtrW'(i);
      if (!win_found && req[cand]) begin
        win_found = 1'b1;
        win_idx   = cand;
      end
    end
  end

  always_comb begin
    win_msg = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (win_idx == PtrW'(i)) begin
        win_msg = msg_in[i*MSG_W +: MSG_W];
      end
    end
  end

  always_comb begin
    state_d  = state_q;
    owner_d  = owner_q;
    rr_ptr_d = rr_ptr_q;
    dwell_d  = dwell_q;
    sel_d    = sel_q;
    grant_d  = grant_q;
    busy_d   = busy_q;
    load_d   = 1'b0;
    ack_d    = '0;
    unique case (state_q)
      StIdle: begin
        if (win_found) begin
          state_d = StLoad;
          owner_d = win_idx;
          grant_d = NUM_REQ'(1) << win_idx;
          sel_d   = win_msg;
          load_d  = 1'b1;
          busy_d  = 1'b1;
        end
      end
      StLoad: begin
        state_d = StWaitLcd;
      end
      StWaitLcd: begin
        if (!lcd_busy) begin
          dwell_d = DwellLoad;
          state_d = StDwell;
        end
      end
      StDwell: begin
        if (dwell_q == '0) begin
          ack_d[owner_q] = 1'b1;
          grant_d        = '0;
          rr_ptr_d       = owner_q + 1'b1;
          busy_d         = 1'b0;
          state_d        = StIdle;
        end else begin
          dwell_d = dwell_q - 1'b1;
        end
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q  <= StIdle;
      owner_q  <= '0;
      rr_ptr_q <= '0;
      dwell_q  <= '0;
      sel_q    <= '0;
      load_q   <= 1'b0;
      grant_q  <= '0;
      ack_q    <= '0;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      owner_q  <= owner_d;
      rr_ptr_q <= rr_ptr_d;
      dwell_q  <= dwell_d;
      sel_q    <= sel_d;
      load_q   <= load_d;
      grant_q  <= grant_d;
      ack_q    <= ack_d;
      busy_q   <= busy_d;
    end
  end

  assign lcd_char_sel = sel_q;
  assign lcd_load     = load_q;
  assign grant        = grant_q;
  assign ack          = ack_q;
  assign busy         = busy_q;

endmodule

// File: tb/tb_lcd_msg_arbiter.sv
// Directed bench for lcd_msg_arbiter with a 4-cycle dwell; expectations are hand-derived.
module tb_lcd_msg_arbiter;

  logic        clk;
  logic        rst;
  logic [3:0]  req;
  logic [15:0] msg_in;
  logic        lcd_busy;
  logic [3:0]  lcd_char_sel;
  logic        lcd_load;
  logic [3:0]  grant;
  logic [3:0]  ack;
  logic        busy;

  int n_cmp = 0;
  int n_err = 0;

  lcd_msg_arbiter #(
    .NUM_REQ      (4),
    .MSG_W        (4),
    .DWELL_CYCLES (4),
    .DW_W         (4)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .req          (req),
    .msg_in       (msg_in),
    .lcd_busy     (lcd_busy),
    .lcd_char_sel (lcd_char_sel),
    .lcd_load     (lcd_load),
    .grant        (grant),
    .ack          (ack),
    .busy         (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  logic [3:0] exp_g;

  initial begin
    rst      = 1'b0;
    req      = 4'hF;
    msg_in   = 16'h0;
    lcd_busy = 1'b0;

    // Reset hold with all requests pending
    tick(); tick(); tick();
    chk("rst_grant", 16'(grant), 16'h0);
    chk("rst_load", 16'(lcd_load), 16'h0);
    chk("rst_sel", 16'(lcd_char_sel), 16'h0);
    chk("rst_busy", 16'(busy), 16'h0);
    chk("rst_ack", 16'(ack), 16'h0);

    rst = 1'b1;
    req = 4'h0;
    tick();
    chk("idle_grant", 16'(grant), 16'h0);

    // Single request from source 2, driver busy for 5 cycles
    req    = 4'b0100;
    msg_in = 16'h0900;
    tick();
    chk("single_grant", 16'(grant), 16'h4);
    chk("single_sel", 16'(lcd_char_sel), 16'h9);
    chk("single_load", 16'(lcd_load), 16'h1);
    chk("single_busy", 16'(busy), 16'h1);
    req      = 4'h0;
    lcd_busy = 1'b1;
    for (int c = 0; c < 5; c++) begin
      tick();
      chk("single_load_low", 16'(lcd_load), 16'h0);
      chk("single_hold", 16'(grant), 16'h4);
    end
    lcd_busy = 1'b0;
    for (int c = 0; c < 4; c++) begin
      tick();
      chk("single_no_ack", 16'(ack), 16'h0);
      chk("single_busy_hi", 16'(busy), 16'h1);
    end
    tick();
    chk("single_ack", 16'(ack), 16'h4);
    chk("single_release", 16'(grant), 16'h0);
    chk("single_busy_lo", 16'(busy), 16'h0);
    chk("single_sel_kept", 16'(lcd_char_sel), 16'h9);
    tick();
    chk("single_ack_pulse", 16'(ack), 16'h0);

    // Round-robin from a fresh pointer with all requests held
    rst = 1'b0;
    tick();
    rst    = 1'b1;
    req    = 4'hF;
    msg_in = 16'h4321;
    for (int g = 0; g < 5; g++) begin
      exp_g = 4'b0001 << (g % 4);
      tick();
      chk("rr_grant", 16'(grant), 16'(exp_g));
      chk("rr_load", 16'(lcd_load), 16'h1);
      chk("rr_sel", 16'(lcd_char_sel), 16'((g % 4) + 1));
      for (int c = 1; c < 6; c++) begin
        tick();
        chk("rr_hold", 16'(grant), 16'(exp_g));
      end
      tick();
      chk("rr_ack", 16'(ack), 16'(exp_g));
      chk("rr_idle", 16'(grant), 16'h0);
    end
    req = 4'h0;

    // Owner 1 withdraws its request during dwell
    req    = 4'b0010;
    msg_in = 16'h00A0;
    tick();
    chk("wd_grant", 16'(grant), 16'h2);
    chk("wd_sel", 16'(lcd_char_sel), 16'hA);
    tick();
    tick();
    req = 4'h0;
    for (int c = 0; c < 3; c++) begin
      tick();
      chk("wd_hold", 16'(grant), 16'h2);
      chk("wd_no_ack", 16'(ack), 16'h0);
    end
    tick();
    chk("wd_ack", 16'(ack), 16'h2);
    chk("wd_release", 16'(grant), 16'h0);
    tick();
    chk("wd_sel_kept", 16'(lcd_char_sel), 16'hA);
    chk("wd_idle", 16'(grant), 16'h0);

    // msg_in changes after grant must not reach lcd_char_sel
    req    = 4'b0100;
    msg_in = 16'h0500;
    tick();
    chk("cap_grant", 16'(grant), 16'h4);
    chk("cap_sel", 16'(lcd_char_sel), 16'h5);
    req    = 4'h0;
    msg_in = 16'hFFFF;
    tick();
    chk("cap_sel_wait", 16'(lcd_char_sel), 16'h5);
    chk("cap_load_wait", 16'(lcd_load), 16'h0);
    msg_in = 16'h1234;
    for (int c = 0; c < 4; c++) begin
      tick();
      chk("cap_sel_dwell", 16'(lcd_char_sel), 16'h5);
      chk("cap_load_dwell", 16'(lcd_load), 16'h0);
    end
    tick();
    chk("cap_ack", 16'(ack), 16'h4);
    chk("cap_sel_end", 16'(lcd_char_sel), 16'h5);

    // Reset while owner 3 is in dwell
    req    = 4'b1000;
    msg_in = 16'h7000;
    tick();
    chk("rd_grant", 16'(grant), 16'h8);
    chk("rd_sel", 16'(lcd_char_sel), 16'h7);
    req = 4'h0;
    tick();
    tick();
    tick();
    rst = 1'b0;
    tick();
    chk("rd_grant0", 16'(grant), 16'h0);
    chk("rd_ack0", 16'(ack), 16'h0);
    chk("rd_sel0", 16'(lcd_char_sel), 16'h0);
    chk("rd_busy0", 16'(busy), 16'h0);
    rst    = 1'b1;
    req    = 4'b1001;
    msg_in = 16'h7003;
    tick();
    chk("rd_regrant", 16'(grant), 16'h1);
    chk("rd_resel", 16'(lcd_char_sel), 16'h3);
    chk("rd_ack_none", 16'(ack), 16'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
